// File: rtl/sha2_padder_if.sv
// Stream-in / schedule-load / block-handshake signals shared by sha2_padder and its environment.
// WIDTH must match the padder instance it is connected to.
interface sha2_padder_if #(
    parameter int WIDTH = 32
) ();
    localparam int BW = $clog2(WIDTH / 8) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [BW-1:0]    in_bytes;
    logic             ms_load;
    logic [WIDTH-1:0] ms_data;
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;

    // Environment side: message source plus compression controller.
    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, ms_load, ms_data, blk_valid, blk_last
    );

    // Padder side.
    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, ms_load, ms_data, blk_valid, blk_last
    );
endinterface

// File: rtl/sha2_padder.sv
// SHA-2 message padder: streams message words into the message schedule, appends
// 0x80 marker, zero fill and bit length, and hands each 16-word block to the controller.
//
// state  | meaning
// S_LOAD | accepting message words, one emitted per accept
// S_PAD  | generating marker / zero / length words, one per cycle
// S_HOLD | block complete, waiting for blk_ready transfer
module sha2_padder #(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input  logic         clk,
    input  logic         rst,
    sha2_padder_if.slave bus
);
    localparam int BPW = WIDTH / 8;
    localparam logic [WIDTH-1:0] MARKER = {8'h80, {(WIDTH-8){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_PAD, S_HOLD} state_e;

    state_e           state_q, state_d;
    logic [3:0]       widx_q, widx_d;
    logic [63:0]      nbytes_q, nbytes_d;
    logic             mark_done_q, mark_done_d;
    logic             final_q, final_d;
    logic             pend_q, pend_d;
    logic             ms_load_q, ms_load_d;
    logic [WIDTH-1:0] ms_data_q, ms_data_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_last_q, blk_last_d;

    logic             in_ready;
    logic             accept;
    logic             xfer;
    logic [63:0]      len_bits;
    logic [WIDTH-1:0] len_hi;
    logic [WIDTH-1:0] len_lo;
    logic [WIDTH-1:0] last_word;
    logic             partial;

    assign len_bits = nbytes_q << 3;

    // 384/512 carry a 128-bit length field whose upper 64 bits are always zero here.
    if (MODE == 384 || MODE == 512) begin : g_len128
        assign len_hi = '0;
        assign len_lo = len_bits[WIDTH-1:0];
    end else begin : g_len64
        assign len_hi = len_bits[63:64-WIDTH];
        assign len_lo = len_bits[WIDTH-1:0];
    end

    assign in_ready = (state_q == S_LOAD) && !rst;
    assign accept   = bus.in_valid && in_ready;
    assign xfer     = blk_valid_q && bus.blk_ready;
    assign partial  = int'(bus.in_bytes) < BPW;

    always_comb begin
        last_word = '0;
        for (int k = 0; k < BPW; k++) begin
            if (k < int'(bus.in_bytes)) begin
                last_word[WIDTH-1-8*k -: 8] = bus.in_data[WIDTH-1-8*k -: 8];
            end else if (k == int'(bus.in_bytes)) begin
                last_word[WIDTH-1-8*k -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        nbytes_d    = nbytes_q;
        mark_done_d = mark_done_q;
        final_d     = final_q;
        pend_d      = pend_q;
        ms_load_d   = 1'b0;
        ms_data_d   = ms_data_q;
        blk_valid_d = 1'b0;
        blk_last_d  = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    ms_load_d = 1'b1;
                    widx_d    = widx_q + 4'd1;
                    if (bus.in_last) begin
                        nbytes_d  = nbytes_q + 64'(bus.in_bytes);
                        ms_data_d = last_word;
                        pend_d    = 1'b1;
                        if (partial) begin
                            mark_done_d = 1'b1;
                        end
                        state_d = (widx_q == 4'd15) ? S_HOLD : S_PAD;
                    end else begin
                        nbytes_d  = nbytes_q + 64'(BPW);
                        ms_data_d = bus.in_data;
                        state_d   = (widx_q == 4'd15) ? S_HOLD : S_LOAD;
                    end
                end
            end

            S_PAD: begin
                ms_load_d = 1'b1;
                widx_d    = widx_q + 4'd1;
                if (!mark_done_q) begin
                    ms_data_d   = MARKER;
                    mark_done_d = 1'b1;
                end else if (widx_q == 4'd14) begin
                    // Marker already placed before index 14: this block carries the length.
                    ms_data_d = len_hi;
                    final_d   = 1'b1;
                end else if (widx_q == 4'd15 && final_q) begin
                    ms_data_d = len_lo;
                end else begin
                    ms_data_d = '0;
                end
                if (widx_q == 4'd15) begin
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                blk_valid_d = !xfer;
                blk_last_d  = !xfer && final_q;
                if (xfer) begin
                    if (final_q) begin
                        nbytes_d    = '0;
                        mark_done_d = 1'b0;
                        final_d     = 1'b0;
                        pend_d      = 1'b0;
                        state_d     = S_LOAD;
                    end else if (pend_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            widx_q      <= '0;
            nbytes_q    <= '0;
            mark_done_q <= 1'b0;
            final_q     <= 1'b0;
            pend_q      <= 1'b0;
            ms_load_q   <= 1'b0;
            ms_data_q   <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            nbytes_q    <= nbytes_d;
            mark_done_q <= mark_done_d;
            final_q     <= final_d;
            pend_q      <= pend_d;
            ms_load_q   <= ms_load_d;
            ms_data_q   <= ms_data_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ms_load   = ms_load_q;
    assign bus.ms_data   = ms_data_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_last  = blk_last_q;
endmodule

// File: doc/sha2_padder.md
# sha2_padder

Upstream loader for `sha2_message_schedule`. It accepts a byte-aligned message as a stream of big-endian words and appends the SHA-2 padding: a 0x80 marker, zero fill, and the message bit length. It emits each 512-/1024-bit block as 16 consecutive `ms_load` word writes into the message schedule, then offers the block to the compression controller through a valid/ready handshake. Input stalls until the controller has taken the block.

## Interface
- `WIDTH`, 32: word width; 32 for MODE 224/256, 64 for MODE 384/512.
- `MODE`, 256: SHA-2 variant (224, 256, 384 or 512); selects the length-field size.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  padder accepts a word this cycle.
- `in_data`  in  WIDTH  message word; first byte in bits [WIDTH-1:WIDTH-8].
- `in_last`  in  1  word is the final word of the message.
- `in_bytes`  in  log2(WIDTH/8)+1  valid bytes in the last word, 0..WIDTH/8; ignored unless `in_last`.
- `ms_load`  out  1  one-cycle write strobe to the message schedule `load` input.
- `ms_data`  out  WIDTH  word for the message schedule `data_in`.
- `blk_valid`  out  1  a full block is loaded into the message schedule.
- `blk_last`  out  1  qualifies `blk_valid`: this is the final block of the message.
- `blk_ready`  in  1  controller takes the block; a transfer occurs when `blk_valid & blk_ready`.

## Operation
- State machine has three states: LOAD, PAD, HOLD. Registers:
  - word index `widx` (4 bits);
  - 64-bit byte counter `nbytes`;
  - flags `mark_done` (0x80 emitted) and `final`.
- LOAD:
  - `in_ready = !rst`.
  - On each accept, the word is emitted at index `widx`, then `widx` increments.
  - A non-last word adds WIDTH/8 to `nbytes`.
- Last word with `in_bytes = n`:
  - `nbytes` increases by n.
  - If n < WIDTH/8: bytes 0..n-1 are kept, byte n is forced to 0x80, bytes above n are forced to 0, and `mark_done` is set.
  - If n = WIDTH/8: the word passes unchanged, and the 0x80 marker goes in the next emitted word.
  - Either way, the state moves to PAD.
- PAD: no input accepted; one word is emitted per cycle.
  - If `mark_done` = 0, the word is 0x80 in the MS byte followed by zeros, and `mark_done` is set.
  - Otherwise, at indices 14 and 15 the words form the length field: bit length L = `nbytes`·8 (mod 2^64).
  - Length field for WIDTH=32: index 14 = L[63:32], index 15 = L[31:0].
  - Length field for WIDTH=64: index 14 = 0 (upper half of the 128-bit field), index 15 = L.
  - All other padding words are zero.
  - The length field is written only when `mark_done` was already set before index 14 was reached.
  - Otherwise the block finishes with zeros at 14 and 15, and a second block follows: zeros at 0..13, length at 14..15.
- `final` is set when the block being emitted will carry the length field.
- After index 15 is emitted: `widx` wraps to 0 and the state goes to HOLD.
- HOLD: `in_ready` = 0 and no `ms_load`. On transfer:
  - If `final`: clear `nbytes`, `mark_done` and `final`, and return to LOAD.
  - Else if PAD is pending (last word already seen): go to PAD.
  - Else: go to LOAD.
- A message of 14 full words, or one whose marker lands at index 14 or 15, always produces two blocks.
- `in_bytes = 0` with `in_last` emits a word of 0x80 followed by zeros; this covers the empty message.
- A message length at or above 2^61 bytes wraps modulo 2^64 bits; no error is flagged.

## Timing
- `ms_load` and `ms_data` are registered: the word accepted or generated in cycle t appears in cycle t+1.
- Throughput is one word per cycle in LOAD (when `in_valid` is high) and in PAD.
- `blk_valid` and `blk_last` are registered. They rise in the cycle after the 16th `ms_load` pulse and hold until the transfer edge.
- Reset values: `in_ready`=0 while `rst` is high; `ms_load`=0, `ms_data`=0, `blk_valid`=0, `blk_last`=0. State is LOAD with all counters 0.
- `rst` during any state aborts the message immediately; there is no partial block output afterwards.
- In the first cycle after `rst` falls, `in_ready` = 1.
- `blk_ready` outside HOLD is ignored.
- A gap in `in_valid` in LOAD inserts an idle cycle with no `ms_load`.

## Test plan
- MODE 256, "abc" (`in_data`=0x61626300, `in_bytes`=3, `in_last`) -> `ms_data` sequence:
  - word 0 = 0x61626380, words 1..14 = 0, word 15 = 0x00000018;
  - then `blk_valid`=`blk_last`=1.
- Empty message (`in_bytes`=0, `in_last`) -> word 0 = 0x80000000, words 1..15 = 0, single block with `blk_last`=1.
- 56-byte message (14 full words):
  - block 0: words 14 = 0x80000000, 15 = 0, `blk_last`=0;
  - block 1: words 0..14 = 0, 15 = 0x000001C0, `blk_last`=1.
- 55-byte message (13 full words + last word, `in_bytes`=3) -> word 13 has 0x80 in its LS byte, word 15 = 0x000001B8, one block.
- MODE 512, WIDTH 64, "abc" (0x6162630000000000, `in_bytes`=3):
  - word 0 = 0x6162638000000000, word 14 = 0, word 15 = 0x18.
- Backpressure and reset:
  - hold `blk_ready`=0 for 20 cycles -> `blk_valid` stays high, `in_ready`=0, no `ms_load`;
  - assert `rst` after word 7 -> all outputs 0 next cycle, and a new message after reset pads correctly from word 0.
